// File: rtl/pwm_scan_ctrl.sv
// Round-robin PWM high/low period measurement: one shared counter serves NUM_CH channels,
// publishing one high/low count pair per channel per scan pass.
module pwm_scan_ctrl #(
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         pwm,
    output logic                      busy,
    output logic                      result_valid,
    output logic [2:0]                result_ch,
    output logic [CNT_W-1:0]          result_high,
    output logic [CNT_W-1:0]          result_low,
    output logic                      result_timeout,
    output logic [NUM_CH*CNT_W-1:0]   high_count_all,
    output logic [NUM_CH*CNT_W-1:0]   low_count_all
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        MEAS_HIGH,
        MEAS_LOW,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [2:0]       LAST_CH = 3'(NUM_CH - 1);

    state_t state, state_n;

    logic [NUM_CH-1:0] pwm_meta, pwm_sync, pwm_prev;
    logic [NUM_CH-1:0] rise, fall;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  hi_lat, hi_n;
    logic [2:0]        ch, ch_n;

    logic              lvl_ch, rise_ch, fall_ch;
    logic              load;
    logic [CNT_W-1:0]  res_hi_n, res_lo_n;
    logic              res_to_n;

    // Edge detection runs on every channel so a freshly selected channel is immediately usable.
    assign rise = pwm_sync & ~pwm_prev;
    assign fall = ~pwm_sync & pwm_prev;

    always_comb begin
        lvl_ch  = 1'b0;
        rise_ch = 1'b0;
        fall_ch = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch == 3'(i)) begin
                lvl_ch  = pwm_sync[i];
                rise_ch = rise[i];
                fall_ch = fall[i];
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ch_n     = ch;
        hi_n     = hi_lat;
        load     = 1'b0;
        res_hi_n = hi_lat;
        res_lo_n = '0;
        res_to_n = 1'b0;
        case (state)
            IDLE: begin
                ch_n = '0;
                if (enable) begin
                    state_n = SYNC;
                    cnt_n   = '0;
                end
            end
            SYNC: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (rise_ch) begin
                    state_n = MEAS_HIGH;
                    cnt_n   = CNT_W'(1);
                end else if (cnt == TMO) begin
                    state_n  = DONE;
                    load     = 1'b1;
                    res_to_n = 1'b1;
                    res_hi_n = lvl_ch ? TMO : '0;
                    res_lo_n = lvl_ch ? '0 : TMO;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            MEAS_HIGH: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (fall_ch) begin
                    state_n = MEAS_LOW;
                    hi_n    = cnt;
                    cnt_n   = CNT_W'(1);
                end else if (cnt == TMO) begin
                    state_n  = DONE;
                    load     = 1'b1;
                    res_to_n = 1'b1;
                    res_hi_n = TMO;
                    res_lo_n = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            MEAS_LOW: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (rise_ch) begin
                    state_n  = DONE;
                    load     = 1'b1;
                    res_lo_n = cnt;
                end else if (cnt == TMO) begin
                    state_n  = DONE;
                    load     = 1'b1;
                    res_to_n = 1'b1;
                    res_lo_n = TMO;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                ch_n = (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
                if (enable) begin
                    state_n = SYNC;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Result fields are captured on entry to DONE so they line up with the result_valid pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            pwm_meta       <= '0;
            pwm_sync       <= '0;
            pwm_prev       <= '0;
            cnt            <= '0;
            hi_lat         <= '0;
            ch             <= '0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_ch      <= '0;
            result_high    <= '0;
            result_low     <= '0;
            result_timeout <= 1'b0;
            high_count_all <= '0;
            low_count_all  <= '0;
        end else begin
            pwm_meta     <= pwm;
            pwm_sync     <= pwm_meta;
            pwm_prev     <= pwm_sync;
            state        <= state_n;
            cnt          <= cnt_n;
            hi_lat       <= hi_n;
            ch           <= ch_n;
            busy         <= (state_n != IDLE);
            result_valid <= load;
            if (load) begin
                result_ch      <= ch;
                result_high    <= res_hi_n;
                result_low     <= res_lo_n;
                result_timeout <= res_to_n;
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (ch == 3'(i)) begin
                        high_count_all[i*CNT_W +: CNT_W] <= res_hi_n;
                        low_count_all[i*CNT_W +: CNT_W]  <= res_lo_n;
                    end
                end
            end
        end
    end

endmodule

// File: doc/pwm_scan_ctrl.md
# pwm_scan_ctrl

Time-multiplexed PWM measurement controller. Owns a single high/low cycle-counting datapath and schedules it round-robin across NUM_CH PWM inputs (e.g. R/G/B LED drive channels), producing one high_count/low_count pair per channel per pass. Sits between the PWM sources from the AXI timers in EMBSYS and the GPIO inputs read by the Microblaze, replacing one hw_detect instance per channel.

## Interface
- NUM_CH, 3: number of PWM inputs scanned (2..8)
- CNT_W, 32: width of all count fields
- TIMEOUT, 4096: max cycles per phase before giving up; must be < 2^CNT_W
- clock  in  1  100 MHz system clock
- reset  in  1  one clock; reset is synchronous and active-low (reset==0 resets on the rising edge of clock)
- enable  in  1  1 = scan continuously; 0 = abort and idle
- pwm  in  NUM_CH  asynchronous PWM inputs, bit i = channel i
- busy  out  1  1 whenever state != IDLE
- result_valid  out  1  one-cycle pulse, result_* fields valid
- result_ch  out  3  channel index of current result
- result_high  out  CNT_W  cycles high
- result_low  out  CNT_W  cycles low
- result_timeout  out  1  result produced by timeout
- high_count_all  out  NUM_CH*CNT_W  latest high count per channel, ch i at [i*CNT_W +: CNT_W]
- low_count_all  out  NUM_CH*CNT_W  latest low count per channel, same packing

## Operation
- Every pwm bit passes through a 2-flop synchronizer (s); a per-channel previous register (p) gives rise = s&~p, fall = ~s&p. Edge logic runs on all channels every cycle, so switching channel needs no settle time.
- Single counter cnt (CNT_W), saturating at TIMEOUT; ch pointer.
- States: IDLE, SYNC, MEAS_HIGH, MEAS_LOW, DONE.
- IDLE: ch<=0. enable=1 -> SYNC, cnt<=0.
- SYNC: wait for rise on ch -> MEAS_HIGH, cnt<=1. Else cnt++; cnt==TIMEOUT -> DONE with timeout; level s[ch]=1 gives high=TIMEOUT, low=0, else high=0, low=TIMEOUT.
- MEAS_HIGH: s[ch]=1 -> cnt++. fall -> latch high=cnt, cnt<=1, -> MEAS_LOW. cnt==TIMEOUT with s still 1 -> DONE timeout, high=TIMEOUT, low=0.
- MEAS_LOW: s[ch]=0 -> cnt++. rise -> latch low=cnt, -> DONE. cnt==TIMEOUT with s still 0 -> DONE timeout, high=measured value, low=TIMEOUT.
- DONE (one cycle): result_valid=1, result_* driven from latches, slice ch of *_count_all updated; ch<=(ch==NUM_CH-1)?0:ch+1; enable=1 -> SYNC (cnt<=0), else IDLE.
- enable=0 in SYNC/MEAS_HIGH/MEAS_LOW: immediate -> IDLE, no result, *_count_all unchanged.
- Counts are in clock cycles; a period ending on the rise that ends the low phase is not reused as the start of the next channel's measurement.

## Timing
- Reset: state IDLE, ch=0, cnt=0, synchronizers/prev=0, busy=0, result_valid=0, result_ch=0, result_high=0, result_low=0, result_timeout=0, *_count_all=0.
- All outputs registered. Input-to-edge latency 2 cycles (synchronizer) + 1 (prev).
- result_valid asserts the cycle after the terminating edge/timeout is seen; result_* and *_count_all hold until next DONE.
- Reset mid-measurement dominates all; no result emitted.
- Worst-case per-channel latency: 3*TIMEOUT + 2 cycles.
- Simultaneous enable fall and terminating edge: abort wins, no result.

## Test plan
- Reset low 5 cycles with PWM running -> all outputs 0, busy=0; after release with enable=0, stays IDLE.
- ch0 PWM 20 cycles high / 10 low, enable=1 -> result_ch=0, result_high=20, result_low=10, result_timeout=0; high_count_all[31:0]=20.
- ch0 20/10, ch1 5/45, ch2 33/7 -> results in order ch 0,1,2,0,... with (20,10),(5,45),(33,7); all three slices of *_count_all correct.
- ch1 stuck high, TIMEOUT=64 -> ch1 result_timeout=1, high=64, low=0; scan proceeds to ch2 and returns correct ch2 values.
- ch2 high 12 then stuck low, TIMEOUT=64 -> high=12, low=64, timeout=1.
- enable dropped mid-MEAS_HIGH -> busy=0 next cycle, no result_valid, *_count_all unchanged; re-enable restarts at ch0.
